// File: rtl/ctrl_pkg.sv
// Shared definitions for the UDP transmit arbiter: FSM encoding, broadcast IP
// and default timing constants.
package ctrl_pkg;

    localparam logic [31:0] BCAST_IP        = 32'hFFFF_FFFF;
    localparam int          ARP_TIMEOUT_DEF = 125_000_000;
    localparam int          ARP_RETRY_DEF   = 3;
    localparam int          IFG_CYC_DEF     = 16;

    typedef enum logic [10:0] {
        ST_IDLE     = 11'b000_0000_0001,
        ST_ARB      = 11'b000_0000_0010,
        ST_LOOKUP   = 11'b000_0000_0100,
        ST_CHECK    = 11'b000_0000_1000,
        ST_ARP_REQ  = 11'b000_0001_0000,
        ST_ARP_SEND = 11'b000_0010_0000,
        ST_ARP_WAIT = 11'b000_0100_0000,
        ST_TX_REQ   = 11'b000_1000_0000,
        ST_TX_SEND  = 11'b001_0000_0000,
        ST_FINISH   = 11'b010_0000_0000,
        ST_GAP      = 11'b100_0000_0000
    } state_e;

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/udp_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_pick
    import ctrl_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               hit
);

    logic [IDX_W:0]   cand;
    logic [IDX_W-1:0] cand_idx;

    // ptr is always below NUM_REQ, so one subtraction is enough to wrap.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        hit        = 1'b0;
        cand       = '0;
        cand_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            cand_idx = cand[IDX_W-1:0];
            if (!hit && req[cand_idx]) begin
                hit              = 1'b1;
                winner_idx       = cand_idx;
                winner[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Round-robin owner of the shared UDP/MAC transmit path: latches the winner's
// destination and length, resolves ARP with bounded retries, then sends.
module udp_tx_arbiter
    import ctrl_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int ARP_TIMEOUT = ARP_TIMEOUT_DEF,
    parameter int ARP_RETRY   = ARP_RETRY_DEF,
    parameter int IFG_CYC     = IFG_CYC_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [16*NUM_REQ-1:0] req_len,
    input  logic [32*NUM_REQ-1:0] req_dst_ip,
    input  logic [8*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    done,
    output logic                  err,
    output logic                  busy,
    output logic                  udp_tx_req,
    output logic [15:0]           udp_send_data_length,
    output logic [31:0]           destination_ip_addr,
    input  logic                  udp_rd_en,
    output logic [7:0]            udp_data,
    input  logic                  mac_send_end,
    input  logic                  mac_not_exist,
    input  logic                  arp_found,
    output logic                  arp_request_req
);

    localparam int IDX_W   = idx_width(NUM_REQ);
    localparam int RETRY_W = idx_width(ARP_RETRY + 1);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     win_idx_q, win_idx_d;
    logic [15:0]          len_q, len_d;
    logic [31:0]          ip_q, ip_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [31:0]          cnt_q, cnt_d;
    logic                 abort_q, abort_d;

    logic [NUM_REQ-1:0]   pick_onehot;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_hit;

    // Requesters qualify udp_rd_en with their own grant bit; nothing to do here.
    logic                 unused_rd_en;
    assign unused_rd_en = udp_rd_en;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (req),
        .ptr        (ptr_q),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .hit        (pick_hit)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        win_idx_d = win_idx_q;
        len_d     = len_q;
        ip_d      = ip_q;
        retry_d   = retry_q;
        abort_d   = abort_q;

        unique case (state_q)
            ST_IDLE: begin
                if (|req) state_d = ST_ARB;
            end
            ST_ARB: begin
                // A request withdrawn before arbitration just returns to idle.
                if (pick_hit) begin
                    grant_d   = pick_onehot;
                    win_idx_d = pick_idx;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (pick_onehot[i]) begin
                            len_d = req_len[16*i +: 16];
                            ip_d  = req_dst_ip[32*i +: 32];
                        end
                    end
                    retry_d = '0;
                    abort_d = 1'b0;
                    state_d = ST_LOOKUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOOKUP: state_d = ST_CHECK;
            ST_CHECK: begin
                if (len_q == 16'h0000) begin
                    abort_d = 1'b1;
                    state_d = ST_FINISH;
                end else if (mac_not_exist) begin
                    state_d = ST_ARP_REQ;
                end else begin
                    state_d = ST_TX_REQ;
                end
            end
            ST_ARP_REQ: begin
                retry_d = retry_q + RETRY_W'(1);
                state_d = ST_ARP_SEND;
            end
            ST_ARP_SEND: begin
                if (mac_send_end) state_d = ST_ARP_WAIT;
            end
            ST_ARP_WAIT: begin
                if (arp_found) begin
                    state_d = ST_TX_REQ;
                end else if (cnt_q == 32'(ARP_TIMEOUT - 1)) begin
                    if (retry_q < RETRY_W'(ARP_RETRY)) begin
                        state_d = ST_ARP_REQ;
                    end else begin
                        abort_d = 1'b1;
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_TX_REQ: state_d = ST_TX_SEND;
            ST_TX_SEND: begin
                if (mac_send_end) state_d = ST_FINISH;
            end
            ST_FINISH: begin
                grant_d = '0;
                ptr_d   = (win_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_q + IDX_W'(1);
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (cnt_q == 32'(IFG_CYC - 1)) state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Wait counter: cleared on every state change, saturates instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == ST_ARP_WAIT || state_q == ST_GAP) && cnt_q != 32'hFFFF_FFFF) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            win_idx_q <= '0;
            len_q     <= '0;
            ip_q      <= BCAST_IP;
            retry_q   <= '0;
            cnt_q     <= '0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            win_idx_q <= win_idx_d;
            len_q     <= len_d;
            ip_q      <= ip_d;
            retry_q   <= retry_d;
            cnt_q     <= cnt_d;
            abort_q   <= abort_d;
        end
    end

    always_comb begin
        udp_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) udp_data = udp_data | req_data[8*i +: 8];
        end
    end

    assign grant                = grant_q;
    assign udp_send_data_length = len_q;
    assign destination_ip_addr  = ip_q;
    assign busy                 = (state_q != ST_IDLE);
    assign udp_tx_req           = (state_q == ST_TX_REQ);
    assign arp_request_req      = (state_q == ST_ARP_REQ);
    assign done                 = (state_q == ST_FINISH) ? grant_q : '0;
    assign err                  = (state_q == ST_FINISH) && abort_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed and randomized transactions for udp_tx_arbiter, checked against a
// transaction-level model of the arbitration, ARP and gap timing rules.
module tb_udp_tx_arbiter;

    localparam int NUM    = 3;
    localparam int ARP_TO = 100;
    localparam int RETRY  = 3;
    localparam int IFG    = 16;

    logic          clk;
    logic          rst_n;
    logic [2:0]    req;
    logic [47:0]   req_len;
    logic [95:0]   req_dst_ip;
    logic [23:0]   req_data;
    logic [2:0]    grant;
    logic [2:0]    done;
    logic          err;
    logic          busy;
    logic          udp_tx_req;
    logic [15:0]   udp_send_data_length;
    logic [31:0]   destination_ip_addr;
    logic          udp_rd_en;
    logic [7:0]    udp_data;
    logic          mac_send_end;
    logic          mac_not_exist;
    logic          arp_found;
    logic          arp_request_req;

    logic [15:0]   len_a  [NUM];
    logic [31:0]   ip_a   [NUM];
    logic [7:0]    data_a [NUM];
    logic [2:0]    exp_q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;
    int ptr       = 0;
    int arp_cnt   = 0;
    int tx_cnt    = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;

    assign req_len    = {len_a[2], len_a[1], len_a[0]};
    assign req_dst_ip = {ip_a[2], ip_a[1], ip_a[0]};
    assign req_data   = {data_a[2], data_a[1], data_a[0]};

    udp_tx_arbiter #(
        .NUM_REQ     (NUM),
        .ARP_TIMEOUT (ARP_TO),
        .ARP_RETRY   (RETRY),
        .IFG_CYC     (IFG)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .req                  (req),
        .req_len              (req_len),
        .req_dst_ip           (req_dst_ip),
        .req_data             (req_data),
        .grant                (grant),
        .done                 (done),
        .err                  (err),
        .busy                 (busy),
        .udp_tx_req           (udp_tx_req),
        .udp_send_data_length (udp_send_data_length),
        .destination_ip_addr  (destination_ip_addr),
        .udp_rd_en            (udp_rd_en),
        .udp_data             (udp_data),
        .mac_send_end         (mac_send_end),
        .mac_not_exist        (mac_not_exist),
        .arp_found            (arp_found),
        .arp_request_req      (arp_request_req)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to the next falling edge and tally the pulses seen there.
    task automatic tick();
        @(negedge clk);
        arp_cnt  += int'(arp_request_req);
        tx_cnt   += int'(udp_tx_req);
        done_cnt += int'(|done);
        err_cnt  += int'(err);
    endtask

    // Round-robin rule: first set request at or after ptr, wrapping.
    function automatic int model_pick(input logic [2:0] rv);
        for (int k = 0; k < NUM; k++) begin
            if (rv[(ptr + k) % NUM]) return (ptr + k) % NUM;
        end
        return -1;
    endfunction

    task automatic send_end(input int dly);
        repeat (dly) tick();
        mac_send_end = 1'b1;
        tick();
        mac_send_end = 1'b0;
    endtask

    // One complete transaction starting from idle. found_dly < 0: ARP never answers.
    task automatic do_txn(input logic [2:0] rv, input bit miss, input int found_dly, input int send_dly);
        int w;
        bit zero_len;
        bit abandon;
        int exp_arp;
        int exp_tx;
        int arp0, tx0, done0, err0;
        logic [2:0] g_exp;
        w        = model_pick(rv);
        g_exp    = 3'(32'd1 << w);
        zero_len = (len_a[w] == 16'h0000);
        abandon  = zero_len || (miss && found_dly < 0);
        exp_arp  = (zero_len || !miss) ? 0 : ((found_dly >= 0) ? 1 : RETRY);
        exp_tx   = abandon ? 0 : 1;
        exp_q.push_back(g_exp);
        arp0 = arp_cnt; tx0 = tx_cnt; done0 = done_cnt; err0 = err_cnt;

        req = rv;
        mac_not_exist = miss;
        tick();
        tick();
        check("grant", 64'(grant), 64'(exp_q.pop_front()));
        check("length", 64'(udp_send_data_length), 64'(len_a[w]));
        check("dst_ip", 64'(destination_ip_addr), 64'(ip_a[w]));
        tick();
        // A stray end-of-frame while checking the cache must be ignored.
        mac_send_end = 1'($urandom_range(0, 1));
        tick();
        mac_send_end = 1'b0;
        if (zero_len) begin
            check("zero_len_done_time", 64'(done), 64'(g_exp));
        end else if (!miss) begin
            check("tx_req_latency", 64'(udp_tx_req), 64'd1);
            check("udp_data", 64'(udp_data), 64'(data_a[w]));
            tick();
            send_end(send_dly);
        end else begin
            check("arp_req_first", 64'(arp_request_req), 64'd1);
            tick();
            send_end(send_dly);
            if (found_dly >= 0) begin
                repeat (found_dly) tick();
                arp_found = 1'b1;
                tick();
                arp_found = 1'b0;
                check("tx_after_arp", 64'(udp_tx_req), 64'd1);
                check("udp_data_arp", 64'(udp_data), 64'(data_a[w]));
                tick();
                send_end(send_dly);
            end else begin
                for (int r = 1; r <= RETRY; r++) begin
                    repeat (ARP_TO) tick();
                    if (r < RETRY) begin
                        check("arp_retry_time", 64'(arp_request_req), 64'd1);
                        tick();
                        send_end(send_dly);
                    end
                end
            end
        end
        check("done", 64'(done), 64'(g_exp));
        check("err", 64'(err), 64'(abandon));
        mac_not_exist = 1'b0;
        repeat (IFG) tick();
        check("gap_busy", 64'(busy), 64'd1);
        tick();
        check("idle_busy", 64'(busy), 64'd0);
        check("grant_clear", 64'(grant), 64'd0);
        check("arp_pulses", 64'(arp_cnt - arp0), 64'(exp_arp));
        check("tx_pulses", 64'(tx_cnt - tx0), 64'(exp_tx));
        check("done_pulses", 64'(done_cnt - done0), 64'd1);
        check("err_pulses", 64'(err_cnt - err0), 64'(abandon));
        ptr = (w + 1) % NUM;
    endtask

    initial begin
        int done0;
        int err0;
        int w_abort;
        rst_n = 1'b0; req = '0; mac_send_end = 1'b0; mac_not_exist = 1'b0;
        arp_found = 1'b0; udp_rd_en = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            len_a[i]  = 16'(16'h0100 + i);
            ip_a[i]   = 32'hC0A8_0010 + 32'(i);
            data_a[i] = 8'hA0 + 8'(i);
        end
        repeat (3) tick();

        check("rst_grant", 64'(grant), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_tx_req", 64'(udp_tx_req), 64'd0);
        check("rst_arp_req", 64'(arp_request_req), 64'd0);
        check("rst_length", 64'(udp_send_data_length), 64'd0);
        check("rst_dst_ip", 64'(destination_ip_addr), 64'hFFFF_FFFF);
        check("rst_udp_data", 64'(udp_data), 64'd0);
        rst_n = 1'b1;
        udp_rd_en = 1'b1;
        tick();

        // All three requesting: served 0, 1, 2, 0.
        repeat (4) do_txn(3'b111, 1'b0, 0, 3);

        // Single requester, 0x40 bytes, cache hit.
        len_a[0] = 16'h0040;
        do_txn(3'b001, 1'b0, 0, 5);

        // Reset in the middle of a send: no completion afterwards, pointer back to 0.
        w_abort = model_pick(3'b111);
        req = 3'b111;
        tick();
        tick();
        check("abort_grant", 64'(grant), 64'(3'(32'd1 << w_abort)));
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("async_rst_grant", 64'(grant), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_dst_ip", 64'(destination_ip_addr), 64'hFFFF_FFFF);
        check("async_rst_length", 64'(udp_send_data_length), 64'd0);
        check("async_rst_udp_data", 64'(udp_data), 64'd0);
        req = '0;
        done0 = done_cnt;
        err0 = err_cnt;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("abort_no_done", 64'(done_cnt - done0), 64'd0);
        check("abort_no_err", 64'(err_cnt - err0), 64'd0);
        ptr = 0;
        do_txn(3'b111, 1'b0, 0, 2);

        // Cache miss answered 50 cycles into the wait.
        do_txn(3'b010, 1'b1, 50, 4);

        // Cache miss never answered: three ARP requests, then abandoned.
        do_txn(3'b100, 1'b1, -1, 2);

        // Zero length beats the cache miss and is abandoned straight away.
        len_a[1] = 16'h0000;
        do_txn(3'b010, 1'b1, 0, 0);

        for (int t = 0; t < 10; t++) begin
            logic [2:0] rv;
            bit         miss;
            int         fd;
            rv = 3'($urandom_range(1, 7));
            for (int i = 0; i < NUM; i++) begin
                len_a[i]  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom_range(1, 1500));
                ip_a[i]   = 32'($urandom);
                data_a[i] = 8'($urandom);
            end
            miss = ($urandom_range(0, 2) == 0);
            fd   = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, ARP_TO - 1));
            do_txn(rv, miss, fd, int'($urandom_range(0, 8)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
Shares the single UDP/MAC transmit path between NUM_REQ requesters, for example command reply, AD data stream and status/heartbeat.
- Picks one requester round-robin.
- Latches that requester's destination IP and payload length.
- Resolves the ARP entry, retrying a bounded number of times.
- Issues the UDP send request and steers the winner's byte stream onto udp_data until mac_send_end.
- Sits between the per-source packet builders and the UDP/IP/MAC transmit stack.

Parameters:
NUM_REQ, 3, number of requesters; index 0 is highest priority at reset.
ARP_TIMEOUT, 125_000_000, cycles to wait for arp_found before re-sending the ARP request (1 s at 125 MHz).
ARP_RETRY, 3, ARP requests sent before the transfer is abandoned.
IFG_CYC, 16, idle cycles enforced after each completed or abandoned transfer.

Ports:
clk  in  1  system clock; the only clock.
rst_n  in  1  asynchronous, active-low reset.
req  in  NUM_REQ  per-requester send request; level, held until that requester's done.
req_len  in  16*NUM_REQ  per-requester UDP payload length in bytes; slice i is [16i+15:16i].
req_dst_ip  in  32*NUM_REQ  per-requester destination IP.
req_data  in  8*NUM_REQ  per-requester payload byte.
grant  out  NUM_REQ  one-hot, registered; marks the requester that owns the path.
done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
err  out  1  one-cycle pulse, coincident with done, when the transfer was abandoned.
busy  out  1  high in every state except IDLE.
udp_tx_req  out  1  one-cycle send request to the UDP stack.
udp_send_data_length  out  16  latched length of the granted requester.
destination_ip_addr  out  32  latched destination IP of the granted requester.
udp_rd_en  in  1  UDP stack is consuming payload bytes; passed through to the granted requester's read logic.
udp_data  out  8  combinational mux: req_data slice selected by grant; 8'h00 when grant==0.
mac_send_end  in  1  end-of-frame pulse from the MAC.
mac_not_exist  in  1  ARP cache miss for destination_ip_addr; valid one cycle after the IP changes.
arp_found  in  1  ARP reply received.
arp_request_req  out  1  one-cycle ARP request pulse.

Behaviour:
- Reset values: all outputs 0, except destination_ip_addr = 32'hFFFFFFFF. Round-robin pointer = 0, state = IDLE. Reset mid-transfer aborts immediately; no done or err is emitted.
- One-hot FSM with these states:
  - IDLE: if |req, go to ARB.
  - ARB: pick the first requester with req set, starting at the pointer and wrapping modulo NUM_REQ. Register grant, udp_send_data_length and destination_ip_addr. Clear the retry count. Go to LOOKUP.
  - LOOKUP: one cycle for the ARP cache to settle on the new IP. Go to CHECK.
  - CHECK: if the latched length == 0, go to FINISH with err. Else if mac_not_exist, go to ARP_REQ. Else go to TX_REQ.
  - ARP_REQ: assert arp_request_req, increment the retry count, go to ARP_SEND.
  - ARP_SEND: wait for mac_send_end, then go to ARP_WAIT.
  - ARP_WAIT:
    - arp_found goes to TX_REQ and takes priority over the timeout in the same cycle.
    - If the wait counter reaches ARP_TIMEOUT-1 and retries < ARP_RETRY, go to ARP_REQ.
    - If the wait counter reaches ARP_TIMEOUT-1 and retries == ARP_RETRY, go to FINISH with err.
  - TX_REQ: assert udp_tx_req for 1 cycle, go to TX_SEND.
  - TX_SEND: wait for mac_send_end, go to FINISH.
  - FINISH: drive done[winner]=1 (and err if abandoned) for this one cycle. Clear grant at the end of the cycle. Set pointer = winner+1, wrapping. Go to GAP.
  - GAP: count IFG_CYC cycles, then go to IDLE.
- Latency: req rising in IDLE → grant high 2 cycles later → udp_tx_req high 4 cycles after req on an ARP hit.
- Requests arriving, or dropping, while granted are ignored until the next ARB. A winner that drops req mid-grant still completes and gets done.
- mac_send_end outside ARP_SEND/TX_SEND is ignored.
- The wait counter is 32-bit, runs only in ARP_WAIT and GAP, and clears on every state change; it never wraps.
- grant, udp_send_data_length and destination_ip_addr are stable from ARB through FINISH.

Decomposition:
- Shared package ctrl_pkg holds:
  - the FSM state encodings;
  - the broadcast IP constant 32'hFFFFFFFF;
  - the default timing constants (ARP_TIMEOUT, IFG_CYC).
- One sub-module, rr_pick: combinational round-robin selector. Inputs are req and pointer; outputs are the one-hot winner and its index.

Test Plan:
1. req=3'b001, len 0x0040, ARP hit → grant=001 at cycle 2, udp_tx_req pulse at cycle 4. mac_send_end → done=001 for 1 cycle, err=0, then busy low after IFG_CYC=16 cycles.
2. req=3'b111 held continuously, all ARP hits → grants served in order 001, 010, 100, 001. udp_send_data_length and destination_ip_addr match each winner's slices.
3. mac_not_exist=1, then arp_found 50 cycles after the ARP mac_send_end → exactly one arp_request_req, then udp_tx_req, then done. err=0.
4. ARP_TIMEOUT=100, arp_found never asserted → 3 arp_request_req pulses spaced 100 cycles plus the ARP send time. Then done and err together; no udp_tx_req.
5. req_len=0 → done and err in the cycle after CHECK; no udp_tx_req and no arp_request_req.
6. rst_n low during TX_SEND → all outputs at reset values asynchronously. No done or err after release; the next req is served from pointer 0.
